// File: rtl/dpram_be_sync.sv
// Single-clock true dual-port RAM with byte-lane write enables, post-reset clear,
// write-first/cross-port forwarding and same-word collision flagging.
//
// state    | meaning
// ST_CLEAR | sequencer fills word cnt_q with CLEAR_VALUE, ports ignored, init_busy=1
// ST_READY | normal dual-port read/write operation
module dpram_be_sync #(
  parameter int          ADDR_WIDTH   = 11,
  parameter int          DATA_BYTES   = 4,
  parameter int          OUTREG       = 0,
  parameter int          CLEAR_ON_RST = 1,
  parameter logic [7:0]  CLEAR_VALUE  = 8'h00
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      init_busy,
  output logic                      coll,
  input  logic [ADDR_WIDTH-1:0]     a_addr,
  input  logic [8*DATA_BYTES-1:0]   a_wrdata,
  input  logic [DATA_BYTES-1:0]     a_wrsel,
  input  logic                      a_wren,
  output logic [8*DATA_BYTES-1:0]   a_rddata,
  input  logic [ADDR_WIDTH-1:0]     b_addr,
  input  logic [8*DATA_BYTES-1:0]   b_wrdata,
  input  logic [DATA_BYTES-1:0]     b_wrsel,
  input  logic                      b_wren,
  output logic [8*DATA_BYTES-1:0]   b_rddata
);
  localparam int W     = 8 * DATA_BYTES;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    ready;
  logic                    clr_we;
  logic [DATA_BYTES-1:0]   a_we, b_we;
  logic                    same_addr;
  logic [W-1:0]            a_fwd, b_fwd;
  logic [W-1:0]            rd_a_q, rd_b_q;
  logic                    coll_q;

  logic [DATA_BYTES-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = ST_READY;
    end
  end

  // Clear writes are gated by reset_n so a held reset never disturbs the array.
  always_comb begin
    init_busy = (state_q == ST_CLEAR);
    ready     = (state_q == ST_READY);
    clr_we    = (state_q == ST_CLEAR) && reset_n;
  end

  always_comb begin
    same_addr = (a_addr == b_addr);
    a_we      = {DATA_BYTES{ready && a_wren}} & a_wrsel;
    b_we      = {DATA_BYTES{ready && b_wren}} & b_wrsel;
    a_fwd     = '0;
    b_fwd     = '0;
    // Per lane, both ports see the post-write word; port A wins overlapping lanes.
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (a_we[i])
        a_fwd[i*8 +: 8] = a_wrdata[i*8 +: 8];
      else if (b_we[i] && same_addr)
        a_fwd[i*8 +: 8] = b_wrdata[i*8 +: 8];
      else
        a_fwd[i*8 +: 8] = mem[a_addr][i];

      if (a_we[i] && same_addr)
        b_fwd[i*8 +: 8] = a_wrdata[i*8 +: 8];
      else if (b_we[i])
        b_fwd[i*8 +: 8] = b_wrdata[i*8 +: 8];
      else
        b_fwd[i*8 +: 8] = mem[b_addr][i];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) mem[cnt_q] <= {DATA_BYTES{CLEAR_VALUE}};
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (b_we[i]) mem[b_addr][i] <= b_wrdata[i*8 +: 8];
      if (a_we[i]) mem[a_addr][i] <= a_wrdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
      coll_q <= 1'b0;
    end else if (!ready) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
      coll_q <= 1'b0;
    end else begin
      rd_a_q <= a_fwd;
      rd_b_q <= b_fwd;
      coll_q <= a_wren && b_wren && same_addr && (|(a_wrsel & b_wrsel));
    end
  end

  assign coll = coll_q;

  generate
    if (OUTREG != 0) begin : g_outreg
      logic [W-1:0] out_a_q, out_b_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_a_q <= '0;
          out_b_q <= '0;
        end else if (!ready) begin
          out_a_q <= '0;
          out_b_q <= '0;
        end else begin
          out_a_q <= rd_a_q;
          out_b_q <= rd_b_q;
        end
      end
      assign a_rddata = out_a_q;
      assign b_rddata = out_b_q;
    end else begin : g_noreg
      assign a_rddata = rd_a_q;
      assign b_rddata = rd_b_q;
    end
  endgenerate

endmodule

// File: tb/tb_dpram_be_sync.sv
// Bench for dpram_be_sync: two instances (OUTREG=0 / OUTREG=1) driven in lockstep and
// checked every cycle against a word-array model of the memory.
module tb_dpram_be_sync;
  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;
  localparam logic [31:0] CV1 = 32'h5A5A5A5A;

  logic        clk, reset_n;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0] a_wrdata, b_wrdata;
  logic [3:0]  a_wrsel, b_wrsel;
  logic        a_wren, b_wren;
  logic        busy0, coll0, busy1, coll1;
  logic [31:0] ard0, brd0, ard1, brd1;

  dpram_be_sync #(.ADDR_WIDTH(AW), .DATA_BYTES(4), .OUTREG(0), .CLEAR_ON_RST(1),
                  .CLEAR_VALUE(8'h00)) dut0 (
    .clk(clk), .reset_n(reset_n), .init_busy(busy0), .coll(coll0),
    .a_addr(a_addr), .a_wrdata(a_wrdata), .a_wrsel(a_wrsel), .a_wren(a_wren), .a_rddata(ard0),
    .b_addr(b_addr), .b_wrdata(b_wrdata), .b_wrsel(b_wrsel), .b_wren(b_wren), .b_rddata(brd0));

  dpram_be_sync #(.ADDR_WIDTH(AW), .DATA_BYTES(4), .OUTREG(1), .CLEAR_ON_RST(1),
                  .CLEAR_VALUE(8'h5A)) dut1 (
    .clk(clk), .reset_n(reset_n), .init_busy(busy1), .coll(coll1),
    .a_addr(a_addr), .a_wrdata(a_wrdata), .a_wrsel(a_wrsel), .a_wren(a_wren), .a_rddata(ard1),
    .b_addr(b_addr), .b_wrdata(b_wrdata), .b_wrsel(b_wrsel), .b_wren(b_wren), .b_rddata(brd1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: memory words, clear progress, expected outputs.
  logic [31:0] m0 [DEPTH];
  logic [31:0] m1 [DEPTH];
  int          mcnt;
  bit          mbusy;
  bit          ecoll;
  logic [31:0] e0a, e0b, e1a, e1b, s1a, s1b;

  int vec = 0;
  int err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("busy0", 32'(busy0), 32'(mbusy));
    chk("busy1", 32'(busy1), 32'(mbusy));
    chk("coll0", 32'(coll0), 32'(ecoll));
    chk("coll1", 32'(coll1), 32'(ecoll));
    chk("a_rd0", ard0, e0a);
    chk("b_rd0", brd0, e0b);
    chk("a_rd1", ard1, e1a);
    chk("b_rd1", brd1, e1b);
  endtask

  task automatic model_reset();
    mcnt = 0; mbusy = 1'b1; ecoll = 1'b0;
    e0a = '0; e0b = '0; e1a = '0; e1b = '0; s1a = '0; s1b = '0;
  endtask

  // One clock edge: DUT samples inputs, model applies the same rules, then compare.
  task automatic tick();
    @(posedge clk);
    if (mbusy) begin
      m0[mcnt] = 32'h0;
      m1[mcnt] = CV1;
      mcnt++;
      if (mcnt == DEPTH) mbusy = 1'b0;
      ecoll = 1'b0;
      e0a = '0; e0b = '0; e1a = '0; e1b = '0; s1a = '0; s1b = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (b_wren && b_wrsel[i]) begin
          m0[b_addr][i*8 +: 8] = b_wrdata[i*8 +: 8];
          m1[b_addr][i*8 +: 8] = b_wrdata[i*8 +: 8];
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (a_wren && a_wrsel[i]) begin
          m0[a_addr][i*8 +: 8] = a_wrdata[i*8 +: 8];
          m1[a_addr][i*8 +: 8] = a_wrdata[i*8 +: 8];
        end
      end
      ecoll = a_wren && b_wren && (a_addr == b_addr) && ((a_wrsel & b_wrsel) != 4'h0);
      e1a = s1a; e1b = s1b;
      s1a = m1[a_addr]; s1b = m1[b_addr];
      e0a = m0[a_addr]; e0b = m0[b_addr];
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #3;
    reset_n = 1'b1;
  endtask

  task automatic idle();
    a_wren = 1'b0; b_wren = 1'b0; a_wrsel = 4'h0; b_wrsel = 4'h0;
  endtask

  task automatic sweep();
    idle();
    for (int i = 0; i < DEPTH + 2; i++) begin
      a_addr = AW'(i);
      b_addr = AW'(DEPTH - 1 - i);
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a_addr = '0; b_addr = '0; a_wrdata = '0; b_wrdata = '0;
    idle();
    do_reset();

    // Clear: busy for exactly DEPTH edges, then every word reads the clear value.
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("busy_before_last", 32'(busy0), 32'd1);
    tick();
    chk("busy_after_clear", 32'(busy0), 32'd0);
    sweep();
    chk("clear_val1", ard1, 32'h5A5A5A5A);
    chk("clear_val0", brd0, 32'h0);

    // Cross-port read after write, latency 1 and 2.
    a_addr = 6'h10; a_wrdata = 32'hDEADBEEF; a_wrsel = 4'hF; a_wren = 1'b1; b_addr = 6'h00;
    tick();
    idle(); b_addr = 6'h10;
    tick();
    chk("t2_lat1", brd0, 32'hDEADBEEF);
    tick();
    chk("t2_lat2", brd1, 32'hDEADBEEF);

    // Same-port partial write-first.
    b_addr = 6'h20; b_wrdata = 32'h11223344; b_wrsel = 4'hF; b_wren = 1'b1;
    tick();
    idle();
    a_addr = 6'h20; a_wrdata = 32'hAABBCCDD; a_wrsel = 4'b0101; a_wren = 1'b1;
    tick();
    chk("t3_merge0", ard0, 32'h11BB33DD);
    idle();
    tick();
    chk("t3_merge1", ard1, 32'h11BB33DD);

    // Disjoint lanes on the same word: no collision.
    a_addr = 6'd5; a_wrdata = 32'h000000AA; a_wrsel = 4'b0001; a_wren = 1'b1;
    b_addr = 6'd5; b_wrdata = 32'h0000BB00; b_wrsel = 4'b0010; b_wren = 1'b1;
    tick();
    chk("t4_coll", 32'(coll0), 32'd0);
    chk("t4_low", {16'h0, brd0[15:0]}, 32'h0000BBAA);

    // Full overlap: port A wins, coll pulses one clock.
    a_addr = 6'd7; a_wrdata = 32'h12345678; a_wrsel = 4'hF; a_wren = 1'b1;
    b_addr = 6'd7; b_wrdata = 32'h87654321; b_wrsel = 4'hF; b_wren = 1'b1;
    tick();
    chk("t5_coll", 32'(coll0), 32'd1);
    chk("t5_word", brd0, 32'h12345678);
    idle();
    tick();
    chk("t5_coll_end", 32'(coll1), 32'd0);

    // Random traffic, biased to a few addresses to provoke collisions and forwarding.
    for (int n = 0; n < 3000; n++) begin
      a_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      b_addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      a_wrdata = $urandom;
      b_wrdata = $urandom;
      a_wrsel  = 4'($urandom);
      b_wrsel  = 4'($urandom);
      a_wren   = 1'($urandom);
      b_wren   = 1'($urandom);
      tick();
    end

    // Reset in READY clears outputs immediately; then reset again mid-clear with A writing.
    do_reset();
    a_addr = 6'd9; a_wrdata = 32'hCAFEF00D; a_wrsel = 4'hF; a_wren = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      a_addr = AW'($urandom);
      tick();
    end
    idle();
    a_addr = 6'd9; b_addr = 6'd9;
    tick();
    chk("t6_lost_write", ard0, 32'h0);
    sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
